// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl
//  Purpose  : Front-panel controller for a 24-hour clock. Moves the time
//             counter between RUN and a two-field SET mode (hours, minutes)
//             driven by two buttons. Provides inc auto-repeat, blinking of
//             the field being edited, an inactivity timeout, and a single
//             load pulse that commits the edited time.
//  Revision : 1.0  initial release
// ============================================================================
module time_set_ctrl #(
  parameter int HOLD_CYCLES    = 25000000,  // inc hold time before auto-repeat
  parameter int REPEAT_CYCLES  = 5000000,   // auto-repeat period
  parameter int BLINK_CYCLES   = 25000000,  // blink half-period
  parameter int TIMEOUT_CYCLES = 500000000  // idle cycles in SET before abort
) (
  input  logic       clock,
  input  logic       reset,       // asynchronous, active-low
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hr,
  output logic [5:0] load_min,
  output logic [4:0] disp_hr,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [5:0] blank_mask,
  output logic [1:0] mode
);

  // --------------------------------------------------------------------------
  // Counter widths
  // --------------------------------------------------------------------------
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_COMMIT  = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t          state_q;
  logic            run_en_q;
  logic            load_q;
  logic [4:0]      edit_hr_q;
  logic [5:0]      edit_min_q;
  logic            btn_mode_q;
  logic            btn_inc_q;
  logic [HW-1:0]   hold_q;      // cycles since the last step while inc held; 0 = not armed
  logic            rep_q;       // 1 once the first auto-repeat step has happened
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_ph_q;
  logic [IW-1:0]   idle_q;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic mode_rise;
  logic inc_rise;
  logic in_set;
  logic hold_hit;
  logic inc_step;
  logic set_entry;
  logic timeout_hit;

  assign mode_rise = btn_mode & ~btn_mode_q;
  assign inc_rise  = btn_inc  & ~btn_inc_q;
  assign in_set    = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);

  // First repeat waits HOLD_CYCLES after the initial step, later ones REPEAT_CYCLES
  assign hold_hit  = rep_q ? (hold_q == HW'(REPEAT_CYCLES))
                           : (hold_q == HW'(HOLD_CYCLES));

  // A mode press in the same cycle swallows the step
  assign inc_step  = in_set & ~mode_rise & (inc_rise | (btn_inc & hold_hit));

  // Entering SET_HR from RUN, or SET_MIN from SET_HR
  assign set_entry = mode_rise & ((state_q == ST_RUN) || (state_q == ST_SET_HR));

  assign timeout_hit = in_set & ~mode_rise & ~inc_step &
                       (idle_q == IW'(TIMEOUT_CYCLES - 1));

  // Previous button levels for rising-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
    end
  end

  // Auto-repeat hold counter: armed by a press, cleared on release or mode press
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else if (!in_set || !btn_inc || mode_rise) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else if (inc_step) begin
      hold_q <= HW'(1);
      rep_q  <= ~inc_rise;
    end else if (hold_q != '0) begin
      hold_q <= hold_q + HW'(1);
    end
  end

  // Blink phase generator, restarted so an edited field is visible at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (set_entry || inc_step) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= ~blink_ph_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  // Inactivity counter, only runs while editing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else if (!in_set || mode_rise || inc_step || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IW'(1);
    end
  end

  // Main sequencer: state, edit values and registered control outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      run_en_q   <= 1'b1;
      load_q     <= 1'b0;
      edit_hr_q  <= 5'd0;
      edit_min_q <= 6'd0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (mode_rise) begin
            edit_hr_q  <= cur_hr;
            edit_min_q <= cur_min;
            state_q    <= ST_SET_HR;
            run_en_q   <= 1'b0;
          end
        end
        ST_SET_HR: begin
          if (mode_rise) begin
            state_q <= ST_SET_MIN;
          end else if (timeout_hit) begin
            state_q  <= ST_RUN;
            run_en_q <= 1'b1;
          end else if (inc_step) begin
            edit_hr_q <= (edit_hr_q == 5'd23) ? 5'd0 : edit_hr_q + 5'd1;
          end
        end
        ST_SET_MIN: begin
          if (mode_rise) begin
            state_q <= ST_COMMIT;
            load_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q  <= ST_RUN;
            run_en_q <= 1'b1;
          end else if (inc_step) begin
            edit_min_q <= (edit_min_q == 6'd59) ? 6'd0 : edit_min_q + 6'd1;
          end
        end
        ST_COMMIT: begin
          // Counter stays frozen during the load cycle, resumes next cycle
          state_q  <= ST_RUN;
          run_en_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          run_en_q <= 1'b1;
        end
      endcase
    end
  end

  // Display source and digit blanking
  always_comb begin
    disp_hr    = cur_hr;
    disp_min   = cur_min;
    disp_sec   = cur_sec;
    blank_mask = 6'b000000;
    if (state_q != ST_RUN) begin
      disp_hr  = edit_hr_q;
      disp_min = edit_min_q;
      disp_sec = 6'd0;
    end
    if (state_q == ST_SET_HR) begin
      blank_mask = {blink_ph_q, blink_ph_q, 4'b0000};
    end else if (state_q == ST_SET_MIN) begin
      blank_mask = {2'b00, blink_ph_q, blink_ph_q, 2'b00};
    end
  end

  assign run_en   = run_en_q;
  assign load     = load_q;
  assign load_hr  = edit_hr_q;
  assign load_min = edit_min_q;
  assign mode     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_set_ctrl
//  Purpose  : Self-checking bench for time_set_ctrl using an expectation
//             queue filled as stimulus is driven and drained after each edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_time_set_ctrl;

  localparam int HOLD    = 8;
  localparam int REPEAT  = 4;
  localparam int BLINK   = 5;
  localparam int TIMEOUT = 100;

  localparam int S_MODE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_LOAD  = 2;
  localparam int S_LHR   = 3;
  localparam int S_LMIN  = 4;
  localparam int S_DHR   = 5;
  localparam int S_DMIN  = 6;
  localparam int S_DSEC  = 7;
  localparam int S_BLANK = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hr = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic       run_en;
  logic       load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [4:0] disp_hr;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;
  logic [5:0] blank_mask;
  logic [1:0] mode;

  time_set_ctrl #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT),
    .BLINK_CYCLES  (BLINK),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .run_en    (run_en),
    .load      (load),
    .load_hr   (load_hr),
    .load_min  (load_min),
    .disp_hr   (disp_hr),
    .disp_min  (disp_min),
    .disp_sec  (disp_sec),
    .blank_mask(blank_mask),
    .mode      (mode)
  );

  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   load_pulses = 0;
  int   lp0;
  int   exp_min;

  // Count cycles in which load was high
  always @(posedge clock) if (load === 1'b1) load_pulses++;

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      S_MODE:  return {30'd0, mode};
      S_RUN:   return {31'd0, run_en};
      S_LOAD:  return {31'd0, load};
      S_LHR:   return {27'd0, load_hr};
      S_LMIN:  return {26'd0, load_min};
      S_DHR:   return {27'd0, disp_hr};
      S_DMIN:  return {26'd0, disp_min};
      S_DSEC:  return {26'd0, disp_sec};
      S_BLANK: return {26'd0, blank_mask};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, sig(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drain();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    tick();
    btn_inc = 1'b0;
    tick();
  endtask

  initial begin
    // ---------------- reset and idle RUN ----------------
    cur_hr = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    tick();
    push("rst_mode", S_MODE, 0);
    push("rst_run_en", S_RUN, 1);
    push("rst_load", S_LOAD, 0);
    push("rst_blank", S_BLANK, 0);
    tick();
    reset = 1'b1;
    push("run_mode", S_MODE, 0);
    push("run_run_en", S_RUN, 1);
    push("run_load", S_LOAD, 0);
    push("run_blank", S_BLANK, 0);
    push("run_dhr", S_DHR, 12);
    push("run_dmin", S_DMIN, 34);
    push("run_dsec", S_DSEC, 56);
    tick();
    tick();

    // ---------------- full edit with wraps 23->0, 59->0 ----------------
    cur_hr = 5'd23; cur_min = 6'd59; cur_sec = 6'd30;
    btn_mode = 1'b1;
    push("e1_mode", S_MODE, 1);
    push("e1_run_en", S_RUN, 0);
    push("e1_dhr", S_DHR, 23);
    push("e1_dmin", S_DMIN, 59);
    push("e1_dsec", S_DSEC, 0);
    tick();
    btn_mode = 1'b0;
    tick();
    btn_inc = 1'b1;
    push("e1_hr_wrap", S_DHR, 0);
    push("e1_mode_hr", S_MODE, 1);
    tick();
    btn_inc = 1'b0;
    tick();
    btn_mode = 1'b1;
    push("e1_mode_min", S_MODE, 2);
    tick();
    btn_mode = 1'b0;
    tick();
    btn_inc = 1'b1;
    push("e1_min_wrap", S_DMIN, 0);
    push("e1_dsec_set", S_DSEC, 0);
    tick();
    btn_inc = 1'b0;
    tick();
    lp0 = load_pulses;
    btn_mode = 1'b1;
    push("e1_commit_mode", S_MODE, 3);
    push("e1_load", S_LOAD, 1);
    push("e1_load_hr", S_LHR, 0);
    push("e1_load_min", S_LMIN, 0);
    push("e1_commit_run_en", S_RUN, 0);
    tick();
    btn_mode = 1'b0;
    push("e1_after_mode", S_MODE, 0);
    push("e1_after_load", S_LOAD, 0);
    push("e1_after_run_en", S_RUN, 1);
    push("e1_after_dsec", S_DSEC, 30);
    tick();
    check("e1_load_once", load_pulses - lp0, 1);

    // ---------------- auto-repeat in SET_MIN from 58 ----------------
    cur_hr = 5'd10; cur_min = 6'd58; cur_sec = 6'd0;
    press_mode();
    btn_mode = 1'b1;
    push("ar_mode", S_MODE, 2);
    push("ar_start", S_DMIN, 58);
    tick();
    btn_mode = 1'b0;
    tick();
    exp_min = 58;
    btn_inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 0 || k == HOLD || (k > HOLD && ((k - HOLD) % REPEAT) == 0))
        exp_min = (exp_min + 1) % 60;
      push($sformatf("ar_hold_k%0d", k), S_DMIN, exp_min);
      tick();
    end
    btn_inc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push("ar_released", S_DMIN, 2);
      tick();
    end
    btn_mode = 1'b1;
    push("ar_load_hr", S_LHR, 10);
    push("ar_load_min", S_LMIN, 2);
    push("ar_load", S_LOAD, 1);
    tick();
    btn_mode = 1'b0;
    tick();

    // ---------------- blink in SET_HR ----------------
    cur_hr = 5'd5; cur_min = 6'd6;
    btn_mode = 1'b1;
    push("bl_entry", S_BLANK, 0);
    tick();
    btn_mode = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      push($sformatf("bl_j%0d", j), S_BLANK, ((j / BLINK) % 2) != 0 ? 6'h30 : 6'h00);
      tick();
    end
    btn_inc = 1'b1;
    push("bl_inc_clear", S_BLANK, 0);
    push("bl_inc_hr", S_DHR, 6);
    tick();
    btn_inc = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      push($sformatf("bl_k%0d", k), S_BLANK, ((k / BLINK) % 2) != 0 ? 6'h30 : 6'h00);
      tick();
    end
    btn_mode = 1'b1;
    push("bl_min_entry_mode", S_MODE, 2);
    push("bl_min_entry_blank", S_BLANK, 0);
    tick();
    btn_mode = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      push($sformatf("bl_min_k%0d", k), S_BLANK, ((k / BLINK) % 2) != 0 ? 6'h0C : 6'h00);
      tick();
    end
    press_mode();

    // ---------------- inactivity timeout ----------------
    cur_hr = 5'd7; cur_min = 6'd15;
    press_mode();
    press_inc();
    press_inc();
    btn_inc = 1'b1;
    push("to_hr", S_DHR, 10);
    tick();
    btn_inc = 1'b0;
    tick();
    lp0 = load_pulses;
    repeat (97) tick();
    push("to_still_set", S_MODE, 1);
    tick();
    push("to_mode", S_MODE, 0);
    push("to_run_en", S_RUN, 1);
    push("to_load", S_LOAD, 0);
    push("to_dhr", S_DHR, 7);
    push("to_dmin", S_DMIN, 15);
    tick();
    tick();
    check("to_no_load", load_pulses - lp0, 0);

    // ---------------- simultaneous mode and inc ----------------
    cur_hr = 5'd3; cur_min = 6'd20;
    press_mode();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    push("sim_mode", S_MODE, 2);
    push("sim_hr", S_DHR, 3);
    push("sim_min", S_DMIN, 20);
    tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick();
    btn_mode = 1'b1;
    push("sim_commit_hr", S_LHR, 3);
    push("sim_commit_min", S_LMIN, 20);
    tick();
    btn_mode = 1'b0;
    tick();

    // ---------------- reset during COMMIT ----------------
    press_mode();
    press_mode();
    btn_mode = 1'b1;
    push("rc_commit", S_MODE, 3);
    push("rc_load", S_LOAD, 1);
    tick();
    btn_mode = 1'b0;
    reset = 1'b0;
    #1;
    push("rc_rst_mode", S_MODE, 0);
    push("rc_rst_load", S_LOAD, 0);
    push("rc_rst_run_en", S_RUN, 1);
    drain();
    #1;
    reset = 1'b1;
    push("rc_post_mode", S_MODE, 0);
    push("rc_post_load", S_LOAD, 0);
    push("rc_post_run_en", S_RUN, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
